i2c_reg_access: RTL and testbench
=================================

Name: i2c_reg_access

Overview:
- Register-level I2C transaction sequencer between the ADV7513 configuration/interrupt FSM (upstream) and the byte-level i2c_master (downstream, 20 kHz bus).
- Turns one request {chip_addr, reg_addr, value, rw} into the i2c_master ena/busy command sequence for two transfers:
  - single-register write: addr+W, reg, data.
  - single-register read: addr+W, reg, repeated start, addr+R, data.
- Returns read data, NACK status and a watchdog timeout, so the upstream FSM can read the 0x96 interrupt and 0x42 HPD status registers as well as write configuration.

Parameters:
- BUSY_TIMEOUT, 24'd2_000_000: clk cycles without an i2c_busy edge before a transaction is aborted.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- chip_addr  in  7  7-bit device address, latched on accept.
- reg_addr  in  8  register index, latched on accept.
- value  in  8  write data, latched on accept; ignored for reads.
- rw  in  1  0 = register write, 1 = register read; latched on accept.
- enable  in  1  request; sampled only while done=1.
- done  out  1  block idle and ready; result outputs valid.
- rd_data  out  8  data from the last successful read.
- ack_error  out  1  last transaction saw a NACK or timed out.
- timeout  out  1  last transaction was aborted by the watchdog.
- i2c_busy  in  1  from i2c_master.
- i2c_ack_error  in  1  from i2c_master.
- i2c_data_rd  in  8  from i2c_master.
- i2c_ena  out  1  to i2c_master.
- i2c_addr  out  7  to i2c_master.
- i2c_rw  out  1  to i2c_master.
- i2c_data_wr  out  8  to i2c_master.

Behaviour:
- Reset (async, reset=0):
  - state=S_IDLE; busy_q=0; timer=0.
  - done=1, rd_data=0, ack_error=0, timeout=0.
  - i2c_ena=0, i2c_addr=0, i2c_rw=0, i2c_data_wr=0.
  - Reset mid-transaction drops i2c_ena immediately; the master completes or stops on its own.
- Edge detection: busy_q registers i2c_busy each cycle. rise = i2c_busy & ~busy_q; fall = ~i2c_busy & busy_q.
- Registered done = (state==S_IDLE) & ~busy_q.
- Accept rule: accept when enable=1 and done=1. On accept:
  - done falls on the next edge (one-cycle latency), so a caller checking two cycles later sees it low.
  - Inputs are latched; ack_error, timeout and timer are cleared.
- States:
  - S_IDLE: on accept, drive i2c_ena=1, i2c_addr=chip_addr, i2c_rw=0, i2c_data_wr=reg_addr, then go to S_REG.
  - S_REG: on rise, the register byte is accepted.
    - Write: set i2c_data_wr=value, keeping i2c_rw=0.
    - Read: set i2c_rw=1, so the master issues a repeated start to the same address.
    - Go to S_DATA.
  - S_DATA: on rise, the second command is accepted. Drop i2c_ena (the master issues stop after this byte) and go to S_END.
  - S_END: on fall, the last byte is complete.
    - Read with no error: rd_data <= i2c_data_rd.
    - Go to S_IDLE; done rises on the following edge.
- Error handling:
  - ack_error is set if i2c_ack_error=1 in any cycle outside S_IDLE. The sequence still runs to completion.
  - rd_data is not updated on error.
  - ack_error is sticky until the next accept.
- Watchdog:
  - timer counts in every non-idle state and is cleared on rise or fall.
  - At timer==BUSY_TIMEOUT-1: i2c_ena=0, timeout=1, ack_error=1, go to S_IDLE. done then waits for i2c_busy low.
- A rise and an i2c_ack_error in the same cycle are both honoured.
- enable held high across completion starts a new transaction on the first cycle done=1. Back-to-back requests are legal.
- i2c_busy already high while in S_IDLE (master still stopping) blocks acceptance through done.
- State register uses safe encoding; an unreachable state returns to S_IDLE with i2c_ena=0.

Decomposition:
- Shared package i2c_pkg:
  - state encoding S_IDLE/S_REG/S_DATA/S_END.
  - RW_WRITE=1'b0, RW_READ=1'b1.
  - ADV7513_ADDR=7'h39.
  - register index constants 0x42 and 0x96.
- No sub-module: edge detection and the watchdog are a few lines inline. i2c_master remains a separate existing block.

Test Plan:
- Write 0x39/0x41=0x10 against the i2c_master BFM -> bus shows S, 0x72, 0x41, 0x10, P; done low 1 cycle after accept, high 1 cycle after the final busy fall; ack_error=0.
- Read 0x39/0x96 with BFM returning 0xC0 -> bus shows S, 0x72, 0x96, Sr, 0x73, data, NACK, P; rd_data=0xC0; ack_error=0.
- BFM NACKs the address byte of a write -> sequence completes; done=1, ack_error=1, timeout=0; next accept clears ack_error.
- BFM holds i2c_busy high with no edges after the first rise, BUSY_TIMEOUT=100 -> 100 cycles after the last edge: i2c_ena=0, timeout=1, ack_error=1; done stays 0 until busy drops.
- reset asserted in S_DATA -> i2c_ena=0 asynchronously and all outputs at reset values; after release with busy low, done=1 and a new write completes normally.
- enable held high for 3 writes -> 3 complete bus transactions back-to-back, with no request accepted while done=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and constants shared by the I2C register sequencer and its users.
package i2c_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REG  = 2'd1,
    S_DATA = 2'd2,
    S_END  = 2'd3
  } state_e;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  localparam logic [6:0] ADV7513_ADDR = 7'h39;
  localparam logic [7:0] REG_HPD_STATUS = 8'h42;
  localparam logic [7:0] REG_INT_STATUS = 8'h96;
endpackage

// File: rtl/i2c_reg_access.sv
// i2c_reg_access: sequences one register write or read into i2c_master ena/busy commands,
// with NACK reporting and a watchdog on silent busy.
module i2c_reg_access
  import i2c_pkg::*;
#(
  parameter logic [23:0] BUSY_TIMEOUT = 24'd2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] chip_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] value,
  input  logic       rw,
  input  logic       enable,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       ack_error,
  output logic       timeout,
  input  logic       i2c_busy,
  input  logic       i2c_ack_error,
  input  logic [7:0] i2c_data_rd,
  output logic       i2c_ena,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_data_wr
);
  state_e      state_q, state_d;
  logic        busy_q, done_q, done_d, rw_q, rw_d;
  logic [7:0]  value_q, value_d, rd_data_q, rd_data_d;
  logic [23:0] timer_q, timer_d;
  logic        ack_error_q, ack_error_d, timeout_q, timeout_d;
  logic        ena_q, ena_d, i2c_rw_q, i2c_rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  data_wr_q, data_wr_d;
  logic        rise, fall, accept, abort;
  assign rise   = i2c_busy & ~busy_q;
  assign fall   = ~i2c_busy & busy_q;
  assign accept = (state_q == S_IDLE) & enable & done_q;
  // An edge this cycle restarts the watchdog, so it never aborts on the same cycle
  assign abort  = (state_q != S_IDLE) & ~(rise | fall) & (timer_q == BUSY_TIMEOUT - 24'd1);
  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    value_d     = value_q;
    rd_data_d   = rd_data_q;
    ena_d       = ena_q;
    addr_d      = addr_q;
    i2c_rw_d    = i2c_rw_q;
    data_wr_d   = data_wr_q;
    done_d      = (state_q == S_IDLE) & ~busy_q;
    ack_error_d = accept ? 1'b0 : ack_error_q | ((state_q != S_IDLE) & i2c_ack_error);
    timeout_d   = accept ? 1'b0 : timeout_q;
    timer_d     = accept ? '0 : (state_q == S_IDLE) ? timer_q : (rise | fall) ? '0 : timer_q + 24'd1;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d   = S_REG;
        rw_d      = rw;
        value_d   = value;
        ena_d     = 1'b1;
        addr_d    = chip_addr;
        i2c_rw_d  = RW_WRITE;
        data_wr_d = reg_addr;
      end
      S_REG: if (rise) begin
        state_d   = S_DATA;
        i2c_rw_d  = rw_q;
        data_wr_d = (rw_q == RW_READ) ? data_wr_q : value_q;
      end
      S_DATA: if (rise) begin
        state_d = S_END;
        ena_d   = 1'b0;
      end
      S_END: if (fall) begin
        state_d   = S_IDLE;
        rd_data_d = (rw_q == RW_READ && !ack_error_d) ? i2c_data_rd : rd_data_q;
      end
      default: begin
        state_d = S_IDLE;
        ena_d   = 1'b0;
      end
    endcase
    if (abort) begin
      state_d     = S_IDLE;
      ena_d       = 1'b0;
      timeout_d   = 1'b1;
      ack_error_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b1;
      rw_q        <= 1'b0;
      value_q     <= '0;
      rd_data_q   <= '0;
      timer_q     <= '0;
      ack_error_q <= 1'b0;
      timeout_q   <= 1'b0;
      ena_q       <= 1'b0;
      addr_q      <= '0;
      i2c_rw_q    <= 1'b0;
      data_wr_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= i2c_busy;
      done_q      <= done_d;
      rw_q        <= rw_d;
      value_q     <= value_d;
      rd_data_q   <= rd_data_d;
      timer_q     <= timer_d;
      ack_error_q <= ack_error_d;
      timeout_q   <= timeout_d;
      ena_q       <= ena_d;
      addr_q      <= addr_d;
      i2c_rw_q    <= i2c_rw_d;
      data_wr_q   <= data_wr_d;
    end
  end
  assign done        = done_q;
  assign rd_data     = rd_data_q;
  assign ack_error   = ack_error_q;
  assign timeout     = timeout_q;
  assign i2c_ena     = ena_q;
  assign i2c_addr    = addr_q;
  assign i2c_rw      = i2c_rw_q;
  assign i2c_data_wr = data_wr_q;
endmodule

// File: tb/tb_i2c_reg_access.sv
// tb_i2c_reg_access: drives i2c_reg_access against a behavioural i2c_master and checks
// bus token sequences and result outputs against a transaction-level model.
module tb_i2c_reg_access;
  import i2c_pkg::*;
  localparam int BYTE_CYC = 8;
  localparam int T_S = 'h100, T_SR = 'h101, T_P = 'h102, T_NACK = 'h103;
  logic       clk = 0, reset = 0;
  logic [6:0] chip_addr = 0;
  logic [7:0] reg_addr = 0, value = 0;
  logic       rw = 0, enable = 0;
  logic       done, ack_error, timeout;
  logic [7:0] rd_data;
  logic       i2c_busy, i2c_ack_error;
  logic [7:0] i2c_data_rd;
  logic       i2c_ena, i2c_rw;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data_wr;
  i2c_reg_access #(.BUSY_TIMEOUT(24'd100)) dut (
    .clk(clk), .reset(reset), .chip_addr(chip_addr), .reg_addr(reg_addr), .value(value),
    .rw(rw), .enable(enable), .done(done), .rd_data(rd_data), .ack_error(ack_error),
    .timeout(timeout), .i2c_busy(i2c_busy), .i2c_ack_error(i2c_ack_error),
    .i2c_data_rd(i2c_data_rd), .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_data_wr(i2c_data_wr)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Accept monitor: every ena rise is one accepted request, and done must have been high before it
  logic ena_s = 0, done_s = 1;
  int accept_cnt = 0, bad_cnt = 0;
  always @(negedge clk) begin
    if (i2c_ena && !ena_s) begin
      accept_cnt <= accept_cnt + 1;
      if (!done_s) bad_cnt <= bad_cnt + 1;
    end
    ena_s  <= i2c_ena;
    done_s <= done;
  end
  // Behavioural i2c_master: logs S/Sr/P/NACK markers and byte values seen on the bus
  int q_bus[$];
  bit bfm_nack = 0, bfm_hang = 0, bfm_idle = 1;
  logic [7:0] bfm_rd = 0;
  int fall_cyc = 0, rise_cyc = 0;
  initial begin : bfm
    logic [6:0] a, pa;
    logic r, pr;
    logic [7:0] d;
    bit first, more;
    i2c_busy = 0; i2c_ack_error = 0; i2c_data_rd = 0;
    forever begin
      tick();
      if (i2c_ena) begin
        bfm_idle = 0; first = 1; more = 1;
        a = i2c_addr; r = i2c_rw; d = i2c_data_wr; pa = a; pr = r;
        while (more) begin
          i2c_busy = 1;
          if (first) begin
            rise_cyc = cyc;
            q_bus.push_back(T_S); q_bus.push_back(int'({a, r}));
          end else if (r != pr || a != pa) begin
            q_bus.push_back(T_SR); q_bus.push_back(int'({a, r}));
          end
          for (int i = 0; i < BYTE_CYC; i++) begin
            i2c_ack_error = first && bfm_nack && i == 2;
            tick();
          end
          i2c_ack_error = 0;
          if (first && bfm_hang) begin
            while (bfm_hang) tick();
            i2c_busy = 0; fall_cyc = cyc;
            q_bus.push_back(T_P);
            more = 0;
          end else begin
            if (r) begin i2c_data_rd = bfm_rd; q_bus.push_back(int'(bfm_rd)); end
            else q_bus.push_back(int'(d));
            repeat (BYTE_CYC) tick();
            i2c_busy = 0; fall_cyc = cyc;
            tick();
            if (i2c_ena) begin
              pa = a; pr = r; a = i2c_addr; r = i2c_rw; d = i2c_data_wr; first = 0;
            end else begin
              if (r) q_bus.push_back(T_NACK);
              q_bus.push_back(T_P);
              more = 0;
            end
          end
        end
        bfm_idle = 1;
      end
    end
  end
  // Transaction-level reference: expected bus tokens and last good read value
  int exp_q[$];
  logic [7:0] m_rd = 0;
  task automatic expect_txn(input logic [6:0] a, input logic [7:0] r, input logic [7:0] v,
                            input logic rwi, input bit nack, input logic [7:0] rdv);
    exp_q.push_back(T_S); exp_q.push_back(int'({a, 1'b0})); exp_q.push_back(int'(r));
    if (rwi) begin
      exp_q.push_back(T_SR); exp_q.push_back(int'({a, 1'b1})); exp_q.push_back(int'(rdv));
      exp_q.push_back(T_NACK);
      if (!nack) m_rd = rdv;
    end else exp_q.push_back(int'(v));
    exp_q.push_back(T_P);
  endtask
  task automatic compare_bus(input string tag);
    check({tag, "_len"}, q_bus.size(), exp_q.size());
    for (int i = 0; i < q_bus.size() && i < exp_q.size(); i++) check({tag, "_tok"}, q_bus[i], exp_q[i]);
    q_bus.delete(); exp_q.delete();
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin tick(); n++; end
    check("done_wait", done, 1);
  endtask
  task automatic run_txn(input logic [6:0] a, input logic [7:0] r, input logic [7:0] v,
                         input logic rwi, input bit nack, input logic [7:0] rdv);
    bfm_nack = nack; bfm_rd = rdv;
    wait_done();
    q_bus.delete(); exp_q.delete();
    chip_addr = a; reg_addr = r; value = v; rw = rwi; enable = 1;
    expect_txn(a, r, v, rwi, nack, rdv);
    tick();
    enable = 0;
    check("ena_on_accept", i2c_ena, 1);
    check("addr_on_accept", i2c_addr, a);
    check("rw_on_accept", i2c_rw, 0);
    check("reg_on_accept", i2c_data_wr, r);
    check("done_hold_1cyc", done, 1);
    tick();
    check("done_low", done, 0);
    wait_done();
    check("done_after_fall", cyc - fall_cyc, 2);
    check("ack_error", ack_error, nack);
    check("timeout", timeout, 0);
    check("rd_data", rd_data, m_rd);
    compare_bus(rwi ? "rd_bus" : "wr_bus");
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_rd"}, rd_data, 0);
    check({tag, "_ack"}, ack_error, 0);
    check({tag, "_to"}, timeout, 0);
    check({tag, "_ena"}, i2c_ena, 0);
    check({tag, "_addr"}, i2c_addr, 0);
    check({tag, "_rw"}, i2c_rw, 0);
    check({tag, "_wr"}, i2c_data_wr, 0);
  endtask
  initial begin
    logic [6:0] ba[3];
    logic [7:0] br[3], bv[3];
    int n, base;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1;
    tick();
    run_txn(ADV7513_ADDR, 8'h41, 8'h10, RW_WRITE, 0, 8'h00);
    run_txn(ADV7513_ADDR, REG_INT_STATUS, 8'h00, RW_READ, 0, 8'hC0);
    run_txn(ADV7513_ADDR, 8'h15, 8'h20, RW_WRITE, 1, 8'h00);
    run_txn(ADV7513_ADDR, REG_HPD_STATUS, 8'h00, RW_READ, 0, 8'h60);
    run_txn(ADV7513_ADDR, REG_INT_STATUS, 8'h00, RW_READ, 1, 8'hAA);
    // Watchdog: master hangs with busy high after the first command
    wait_done();
    bfm_hang = 1; bfm_nack = 0;
    chip_addr = ADV7513_ADDR; reg_addr = 8'h98; value = 8'h03; rw = RW_WRITE; enable = 1;
    tick();
    enable = 0;
    n = 0;
    while (!i2c_busy && n < 100) begin tick(); n++; end
    check("hang_busy", i2c_busy, 1);
    while (cyc < rise_cyc + 100) tick();
    check("to_early_timeout", timeout, 0);
    check("to_early_ena", i2c_ena, 1);
    tick();
    check("to_timeout", timeout, 1);
    check("to_ena", i2c_ena, 0);
    check("to_ack", ack_error, 1);
    check("to_done", done, 0);
    repeat (20) tick();
    check("to_done_held", done, 0);
    bfm_hang = 0;
    wait_done();
    check("to_timeout_kept", timeout, 1);
    check("to_ack_kept", ack_error, 1);
    run_txn(ADV7513_ADDR, 8'hAF, 8'h06, RW_WRITE, 0, 8'h00);
    // Asynchronous reset while the sequencer sits in S_DATA
    wait_done();
    chip_addr = ADV7513_ADDR; reg_addr = 8'h22; value = 8'h5A; rw = RW_WRITE; enable = 1;
    tick();
    enable = 0;
    n = 0;
    while (!i2c_busy && n < 100) begin tick(); n++; end
    check("rst_busy", i2c_busy, 1);
    tick();
    #2 reset = 0;
    #1 check_reset_vals("midreset");
    m_rd = 0;
    n = 0;
    while (!bfm_idle && n < 200) begin tick(); n++; end
    check("rst_bfm_idle", bfm_idle, 1);
    reset = 1;
    tick();
    check("rst_done", done, 1);
    run_txn(ADV7513_ADDR, 8'hD6, 8'hC0, RW_WRITE, 0, 8'h00);
    // Three writes with enable held high throughout
    wait_done();
    q_bus.delete(); exp_q.delete();
    bfm_nack = 0;
    for (int i = 0; i < 3; i++) begin
      ba[i] = 7'($urandom); br[i] = 8'($urandom); bv[i] = 8'($urandom);
      expect_txn(ba[i], br[i], bv[i], RW_WRITE, 0, 8'h00);
    end
    base = accept_cnt;
    chip_addr = ba[0]; reg_addr = br[0]; value = bv[0]; rw = RW_WRITE; enable = 1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (accept_cnt < base + i + 1 && n < 2000) begin tick(); n++; end
      check("b2b_accept_wait", accept_cnt - base, i + 1);
      if (i < 2) begin chip_addr = ba[i+1]; reg_addr = br[i+1]; value = bv[i+1]; end
      else enable = 0;
    end
    wait_done();
    repeat (5) tick();
    check("b2b_accepts", accept_cnt - base, 3);
    compare_bus("b2b_bus");
    // Randomized mix of writes and reads, some NACKed
    for (int i = 0; i < 12; i++)
      run_txn(7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) == 0, 8'($urandom));
    check("accept_while_busy", bad_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
